// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter and bus sequencer for three bus masters.
// Grants one master at a time with a one-hot ack, registers the granted
// master's data onto the shared bus, caps each tenure at MAX_HOLD transfers
// and inserts a single turnaround cycle between tenures.
module rr_bus_arbiter #(
  parameter int DATA_W   = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  // Last transfer of a tenure is the one taken when hold_cnt hits this value.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state;
  logic [1:0]  gnt;
  logic [1:0]  last;
  logic [7:0]  hold_cnt;

  logic [1:0]        c1, c2, pick;
  logic [DATA_W-1:0] data_sel;

  // Modulo-3 increment over master indices 0..2.
  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search starting just after the last granted master.
  always_comb begin
    c1   = inc3(last);
    c2   = inc3(c1);
    pick = last;
    if (req[c1])      pick = c1;
    else if (req[c2]) pick = c2;
  end

  // Data from the master currently owning the bus.
  always_comb begin
    case (gnt)
      2'd0:    data_sel = data_in1;
      2'd1:    data_sel = data_in2;
      default: data_sel = data_in3;
    endcase
  end

  assign busy = (state != IDLE);

  // Arbitration FSM with registered ack and bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= 2'd0;
      last      <= 2'd2;
      hold_cnt  <= 8'd0;
      ack       <= 3'b000;
      bus_data  <= '0;
      bus_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack       <= 3'b000;
          bus_valid <= 1'b0;
          if (|req) begin
            gnt      <= pick;
            last     <= pick;
            ack      <= 3'b001 << pick;
            hold_cnt <= 8'd0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt]) begin
            // Master let go: no transfer this edge.
            ack       <= 3'b000;
            bus_valid <= 1'b0;
            state     <= TURN;
          end else begin
            bus_data  <= data_sel;
            bus_valid <= 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              ack   <= 3'b000;
              state <= TURN;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        TURN: begin
          ack       <= 3'b000;
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          ack       <= 3'b000;
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed testbench for rr_bus_arbiter: a MAX_HOLD=8 instance and a
// MAX_HOLD=2 instance share the same stimulus; each scenario starts from reset.
module tb_rr_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic [1:0] d1 = 2'd0, d2 = 2'd0, d3 = 2'd0;

  logic [2:0] ack8, ack2;
  logic [1:0] data8, data2;
  logic       valid8, valid2, busy8, busy2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.DATA_W(2), .MAX_HOLD(8)) u_dut8 (
    .clk(clk), .reset(reset), .req(req),
    .data_in1(d1), .data_in2(d2), .data_in3(d3),
    .ack(ack8), .bus_data(data8), .bus_valid(valid8), .busy(busy8)
  );

  rr_bus_arbiter #(.DATA_W(2), .MAX_HOLD(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req),
    .data_in1(d1), .data_in2(d2), .data_in3(d3),
    .ack(ack2), .bus_data(data2), .bus_valid(valid2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release just after an edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 3'b111;
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (ack8 !== 3'b000) $display("FAIL reset_ack got=%b exp=000", ack8); else passed++;
    checks++;
    if (data8 !== 2'd0) $display("FAIL reset_data got=%0d exp=0", data8); else passed++;
    checks++;
    if (valid8 !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid8); else passed++;
    checks++;
    if (busy8 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy8); else passed++;
    reset = 1'b0;
    tick();
    checks++;
    if (ack8 !== 3'b001) $display("FAIL reset_first_grant got=%b exp=001", ack8); else passed++;
    req = 3'b000;
  endtask

  task automatic test_single_master();
    req = 3'b000; d2 = 2'b10;
    do_reset();
    req = 3'b010;
    tick();
    checks++;
    if (ack8 !== 3'b010 || valid8 !== 1'b0)
      $display("FAIL single_grant ack=%b valid=%b exp ack=010 valid=0", ack8, valid8);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ack8 !== 3'b010 || valid8 !== 1'b1 || data8 !== 2'b10)
        $display("FAIL single_xfer%0d ack=%b valid=%b data=%b exp ack=010 valid=1 data=10",
                 i, ack8, valid8, data8);
      else passed++;
    end
    req = 3'b000;
    tick();
    checks++;
    if (ack8 !== 3'b000 || valid8 !== 1'b0 || busy8 !== 1'b1)
      $display("FAIL single_release ack=%b valid=%b busy=%b exp 000/0/1", ack8, valid8, busy8);
    else passed++;
    tick();
    checks++;
    if (busy8 !== 1'b0 || ack8 !== 3'b000 || data8 !== 2'b10)
      $display("FAIL single_idle busy=%b ack=%b data=%b exp 0/000/10", busy8, ack8, data8);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ack [14] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000,
                                 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b001, 3'b001};
    logic       exp_vld [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_dat [14] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
    d1 = 2'd1; d2 = 2'd2; d3 = 2'd3;
    req = 3'b111;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if (ack2 !== exp_ack[i] || valid2 !== exp_vld[i] || data2 !== exp_dat[i])
        $display("FAIL rr_edge%0d ack=%b valid=%b data=%0d exp ack=%b valid=%b data=%0d",
                 i + 1, ack2, valid2, data2, exp_ack[i], exp_vld[i], exp_dat[i]);
      else passed++;
    end
    req = 3'b000;
  endtask

  task automatic test_forced_release();
    d1 = 2'd3;
    req = 3'b000;
    do_reset();
    req = 3'b001;
    tick();
    checks++;
    if (ack8 !== 3'b001) $display("FAIL forced_grant got=%b exp=001", ack8); else passed++;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (valid8 !== 1'b1 || data8 !== 2'd3 || ack8 !== ((i == 7) ? 3'b000 : 3'b001))
        $display("FAIL forced_xfer%0d ack=%b valid=%b data=%0d exp ack=%b valid=1 data=3",
                 i, ack8, valid8, data8, (i == 7) ? 3'b000 : 3'b001);
      else passed++;
    end
    tick();
    checks++;
    if (ack8 !== 3'b000 || valid8 !== 1'b0)
      $display("FAIL forced_turn ack=%b valid=%b exp 000/0", ack8, valid8);
    else passed++;
    tick();
    checks++;
    if (ack8 !== 3'b001 || valid8 !== 1'b0)
      $display("FAIL forced_regrant ack=%b valid=%b exp 001/0", ack8, valid8);
    else passed++;
    tick();
    checks++;
    if (valid8 !== 1'b1) $display("FAIL forced_resume valid=%b exp=1", valid8); else passed++;
    req = 3'b000;
  endtask

  task automatic test_reset_mid_tenure();
    d3 = 2'd3;
    req = 3'b000;
    do_reset();
    req = 3'b100;
    tick();
    checks++;
    if (ack8 !== 3'b100) $display("FAIL midrst_grant got=%b exp=100", ack8); else passed++;
    repeat (3) tick();
    checks++;
    if (valid8 !== 1'b1 || data8 !== 2'd3)
      $display("FAIL midrst_xfer3 valid=%b data=%0d exp 1/3", valid8, data8);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ack8 !== 3'b000 || data8 !== 2'd0 || valid8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL midrst_clear ack=%b data=%0d valid=%b busy=%b exp 000/0/0/0",
               ack8, data8, valid8, busy8);
    else passed++;
    req = 3'b110;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (ack8 !== 3'b010) $display("FAIL midrst_regrant got=%b exp=010", ack8); else passed++;
    req = 3'b000;
  endtask

  task automatic test_zero_transfer();
    d3 = 2'd1;
    req = 3'b000;
    do_reset();
    req = 3'b100;
    tick();
    checks++;
    if (ack8 !== 3'b100 || valid8 !== 1'b0)
      $display("FAIL zero_grant ack=%b valid=%b exp 100/0", ack8, valid8);
    else passed++;
    req = 3'b000;
    tick();
    checks++;
    if (ack8 !== 3'b000 || valid8 !== 1'b0 || data8 !== 2'd0 || busy8 !== 1'b1)
      $display("FAIL zero_release ack=%b valid=%b data=%0d busy=%b exp 000/0/0/1",
               ack8, valid8, data8, busy8);
    else passed++;
    tick();
    checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || data8 !== 2'd0)
      $display("FAIL zero_idle busy=%b valid=%b data=%0d exp 0/0/0", busy8, valid8, data8);
    else passed++;
    // last must still point at master 3, so master 1 wins next.
    req = 3'b111;
    tick();
    checks++;
    if (ack8 !== 3'b001) $display("FAIL zero_next_grant got=%b exp=001", ack8); else passed++;
    req = 3'b000;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_master();
    test_round_robin();
    test_forced_release();
    test_reset_mid_tenure();
    test_zero_transfer();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
